// File: rtl/output_accum_pkg.sv
// Shared types and arithmetic helpers for the output accumulator.
// Saturation works on a wide signed carrier; callers truncate to the target width.
package output_accum_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain
    } state_e;

    localparam int unsigned MaxW = 64;
    localparam logic signed [MaxW-1:0] One = 64'sd1;

    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned guard);
        return dw + guard;
    endfunction

    function automatic logic signed [MaxW-1:0] sat_width(input logic signed [MaxW-1:0] v,
                                                         input int unsigned w);
        logic signed [MaxW-1:0] hi;
        logic signed [MaxW-1:0] lo;
        hi = (One <<< (w - 1)) - One;
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic signed [MaxW-1:0] sat_to_acc(input logic signed [MaxW-1:0] v,
                                                          input int unsigned acc_w);
        return sat_width(v, acc_w);
    endfunction

    function automatic logic signed [MaxW-1:0] sat_to_dw(input logic signed [MaxW-1:0] v,
                                                         input int unsigned dw);
        return sat_width(v, dw);
    endfunction

endpackage

// File: rtl/accum_ram.sv
// Simple dual-port accumulator RAM: one read port with 1-cycle latency, one write port.
// Read data holds its last value while rd_en_i is low.
module accum_ram #(
    parameter int unsigned AW = 11,
    parameter int unsigned W  = 20
) (
    input  logic          clk_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i
);

    localparam int unsigned Depth = 2 ** AW;

    logic [W-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/output_accum_block.sv
// Column accumulator: masked vectors are read-modify-written into a RAM with saturation,
// then drained as a stream of DW-saturated words with optional clear-on-read.
module output_accum_block
    import output_accum_pkg::*;
#(
    parameter int unsigned N_COLS_ARRAY    = 3,
    parameter int unsigned I_WIDTH         = 8,
    parameter int unsigned F_WIDTH         = 8,
    parameter int unsigned GUARD_BITS      = 4,
    parameter int unsigned BRAM_ADDR_WIDTH = 11,
    localparam int unsigned DW = I_WIDTH + F_WIDTH,
    localparam int unsigned AW = BRAM_ADDR_WIDTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic signed [N_COLS_ARRAY-1:0][DW-1:0] data_in_i,
    input  logic [N_COLS_ARRAY-1:0]              col_mask_i,
    input  logic [AW-1:0]                        base_addr_i,
    input  logic                                 first_pass_i,
    input  logic                                 drain_start_i,
    input  logic [AW-1:0]                        drain_addr_i,
    input  logic [AW:0]                          drain_len_i,
    input  logic                                 drain_clear_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic signed [DW-1:0]                 out_data_o,
    output logic                                 sat_flag_o,
    input  logic                                 sat_clr_i,
    output logic                                 busy_o,
    output logic                                 done_o
);

    localparam int unsigned ACC_W = acc_width(DW, GUARD_BITS);
    localparam int unsigned IdxW  = (N_COLS_ARRAY > 1) ? $clog2(N_COLS_ARRAY) : 1;

    state_e state_q, state_d;

    logic [N_COLS_ARRAY-1:0][DW-1:0] data_q;
    logic [N_COLS_ARRAY-1:0]         rem_q;
    logic [AW-1:0]                   base_q;
    logic                            fp_q;

    logic              s2_valid_q;
    logic [AW-1:0]     s2_addr_q;
    logic [DW-1:0]     s2_col_q;
    logic              s2_fp_q;
    logic              s2_fwd_q;
    logic [ACC_W-1:0]  s2_fwd_data_q;

    logic [AW-1:0] cur_addr_q;
    logic [AW:0]   drem_q;
    logic          dclr_q;
    logic          out_valid_q;
    logic          done_q;
    logic          sat_q;

    logic [IdxW-1:0]  acc_idx;
    logic [AW-1:0]    acc_addr;
    logic             acc_last;
    logic             accept;
    logic             drain_go;
    logic             xfer;
    logic             last_xfer;

    logic             ram_rd_en;
    logic [AW-1:0]    ram_rd_addr;
    logic [ACC_W-1:0] ram_rd_data;
    logic             ram_wr_en;
    logic [AW-1:0]    ram_wr_addr;
    logic [ACC_W-1:0] ram_wr_data;

    logic [ACC_W-1:0]       old_val;
    logic signed [MaxW-1:0] col_ext;
    logic signed [MaxW-1:0] old_ext;
    logic signed [MaxW-1:0] sum_full;
    logic signed [MaxW-1:0] sum_sat;
    logic signed [MaxW-1:0] rd_ext;
    logic [ACC_W-1:0]       acc_wr;
    logic                   clip;

    // Lowest remaining mask bit selects the column processed this cycle.
    always_comb begin
        acc_idx = '0;
        for (int i = N_COLS_ARRAY - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                acc_idx = IdxW'(i);
            end
        end
    end

    assign acc_addr  = base_q + AW'(acc_idx);
    assign acc_last  = (rem_q & (rem_q - N_COLS_ARRAY'(1))) == '0;
    assign accept    = in_valid_i & in_ready_o;
    assign drain_go  = (state_q == StIdle) & drain_start_i & ~s2_valid_q;
    assign xfer      = (state_q == StDrain) & out_valid_q & out_ready_i;
    assign last_xfer = xfer & (drem_q == (AW + 1)'(1));

    // Stage 2 arithmetic; forwarded data covers a write still in flight to the same word.
    always_comb begin
        old_val  = s2_fwd_q ? s2_fwd_data_q : ram_rd_data;
        col_ext  = {{(MaxW - DW){s2_col_q[DW-1]}}, s2_col_q};
        old_ext  = s2_fp_q ? '0 : {{(MaxW - ACC_W){old_val[ACC_W-1]}}, old_val};
        sum_full = col_ext + old_ext;
        sum_sat  = sat_to_acc(sum_full, ACC_W);
        acc_wr   = ACC_W'(sum_sat);
        clip     = s2_valid_q & (sum_sat != sum_full);
        rd_ext   = {{(MaxW - ACC_W){ram_rd_data[ACC_W-1]}}, ram_rd_data};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (drain_go) begin
                    state_d = (drain_len_i != '0) ? StDrain : StIdle;
                end else if (accept && (col_mask_i != '0)) begin
                    state_d = StAccum;
                end
            end
            StAccum: if (acc_last) state_d = StIdle;
            StDrain: if (last_xfer) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == StIdle) & ~drain_start_i;
        busy_o      = (state_q != StIdle) | s2_valid_q;
        out_valid_o = out_valid_q;
        out_data_o  = out_valid_q ? DW'(sat_to_dw(rd_ext, DW)) : '0;
        sat_flag_o  = sat_q;
        done_o      = done_q;
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        unique case (state_q)
            StIdle: begin
                if (drain_go && (drain_len_i != '0)) begin
                    ram_rd_en   = 1'b1;
                    ram_rd_addr = drain_addr_i;
                end
            end
            StAccum: begin
                ram_rd_en   = 1'b1;
                ram_rd_addr = acc_addr;
            end
            StDrain: begin
                if (xfer && !last_xfer) begin
                    ram_rd_en   = 1'b1;
                    ram_rd_addr = cur_addr_q + AW'(1);
                end
            end
            default: ;
        endcase
        // Stage 2 and drain clears never overlap: a drain only starts with stage 2 empty.
        ram_wr_en   = s2_valid_q | (xfer & dclr_q);
        ram_wr_addr = s2_valid_q ? s2_addr_q : cur_addr_q;
        ram_wr_data = s2_valid_q ? acc_wr : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q        <= '0;
            rem_q         <= '0;
            base_q        <= '0;
            fp_q          <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_addr_q     <= '0;
            s2_col_q      <= '0;
            s2_fp_q       <= 1'b0;
            s2_fwd_q      <= 1'b0;
            s2_fwd_data_q <= '0;
            cur_addr_q    <= '0;
            drem_q        <= '0;
            dclr_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept && !drain_go) begin
                data_q <= data_in_i;
                rem_q  <= col_mask_i;
                base_q <= base_addr_i;
                fp_q   <= first_pass_i;
            end else if (state_q == StAccum) begin
                rem_q <= rem_q & (rem_q - N_COLS_ARRAY'(1));
            end

            s2_valid_q    <= (state_q == StAccum);
            s2_addr_q     <= acc_addr;
            s2_col_q      <= data_q[acc_idx];
            s2_fp_q       <= fp_q;
            s2_fwd_q      <= (state_q == StAccum) & s2_valid_q & (s2_addr_q == acc_addr);
            s2_fwd_data_q <= acc_wr;

            if (drain_go) begin
                cur_addr_q  <= drain_addr_i;
                drem_q      <= drain_len_i;
                dclr_q      <= drain_clear_i;
                out_valid_q <= (drain_len_i != '0);
                done_q      <= (drain_len_i == '0);
            end else if (xfer) begin
                cur_addr_q <= cur_addr_q + AW'(1);
                drem_q     <= drem_q - (AW + 1)'(1);
                if (last_xfer) begin
                    out_valid_q <= 1'b0;
                    done_q      <= 1'b1;
                end
            end

            // A clip in the same cycle as a clear request keeps the flag set.
            if (clip) begin
                sat_q <= 1'b1;
            end else if (sat_clr_i) begin
                sat_q <= 1'b0;
            end
        end
    end

    accum_ram #(
        .AW (AW),
        .W  (ACC_W)
    ) u_ram (
        .clk_i     (clk_i),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (ram_rd_addr),
        .rd_data_o (ram_rd_data),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (ram_wr_addr),
        .wr_data_i (ram_wr_data)
    );

endmodule
